// File: rtl/ddr2_port_responder.sv
// rtl/ddr2_port_responder.sv - RAM-backed stand-in for the DDR2 write/read ports with round-robin arbitration and programmable latency
// Optional completion counters are enabled by defining DDR2_RESP_STATS_EN.
module ddr2_port_responder #(
  parameter int DEPTH   = 640,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        ctrl_clk,
  input  logic        reset_n,
  input  logic [31:0] write_addr,
  input  logic [31:0] iData,
  input  logic        write,
  output logic        write_waitrequest,
  input  logic [31:0] read_addr,
  input  logic        read,
  output logic        read_waitrequest,
  output logic [31:0] oData,
  output logic [31:0] wr_count,
  output logic [31:0] rd_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY_WR,
    S_BUSY_RD,
    S_ACK_WR,
    S_ACK_RD
  } state_e;

  localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);
  localparam logic [31:0] LIMIT    = 32'(DEPTH * 4);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                inr_q, inr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                last_rd_q, last_rd_d;
  logic [31:0]         odata_q, odata_d;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         ram_rdata_q;
  logic                ram_we, ram_re;
  logic                grant_wr, grant_rd;
  logic                wr_inr, rd_inr;

  assign wr_inr = (write_addr < LIMIT);
  assign rd_inr = (read_addr < LIMIT);

  always_ff @(posedge ctrl_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      inr_q     <= 1'b0;
      wdata_q   <= '0;
      last_rd_q <= 1'b1;
      odata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      inr_q     <= inr_d;
      wdata_q   <= wdata_d;
      last_rd_q <= last_rd_d;
      odata_q   <= odata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    inr_d     = inr_q;
    wdata_d   = wdata_q;
    last_rd_d = last_rd_q;
    odata_d   = odata_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // On a tie, serve the port that did not complete last.
        if (write && read) begin
          grant_wr = last_rd_q;
          grant_rd = !last_rd_q;
        end else begin
          grant_wr = write;
          grant_rd = read;
        end
        if (grant_wr) begin
          state_d = S_BUSY_WR;
          idx_d   = write_addr[ADDR_W+1:2];
          inr_d   = wr_inr;
          wdata_d = iData;
          cnt_d   = LAT_LOAD;
        end else if (grant_rd) begin
          state_d = S_BUSY_RD;
          idx_d   = read_addr[ADDR_W+1:2];
          inr_d   = rd_inr;
          cnt_d   = LAT_LOAD;
          ram_re  = rd_inr;
        end
      end
      S_BUSY_WR: begin
        if (!write) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK_WR;
        end else begin
          cnt_d = 4'(cnt_q - 4'd1);
        end
      end
      S_BUSY_RD: begin
        if (!read) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK_RD;
          odata_d = inr_q ? ram_rdata_q : 32'h0;
        end else begin
          cnt_d = 4'(cnt_q - 4'd1);
        end
      end
      S_ACK_WR: begin
        ram_we    = inr_q;
        last_rd_d = 1'b0;
        state_d   = S_IDLE;
      end
      S_ACK_RD: begin
        last_rd_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single-port array: the write (ACK_WR) and the read (IDLE grant) never coincide.
  always_ff @(posedge ctrl_clk) begin
    if (ram_we) begin
      mem[idx_q] <= wdata_q;
    end
    if (ram_re) begin
      ram_rdata_q <= mem[read_addr[ADDR_W+1:2]];
    end
  end

  assign write_waitrequest = (state_q != S_ACK_WR);
  assign read_waitrequest  = (state_q != S_ACK_RD);
  assign oData             = odata_q;

`ifdef DDR2_RESP_STATS_EN
  logic [31:0] wr_cnt_q, rd_cnt_q;

  always_ff @(posedge ctrl_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (state_q == S_ACK_WR) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (state_q == S_ACK_RD) rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;
`else
  assign wr_count = 32'h0;
  assign rd_count = 32'h0;
`endif

endmodule

// File: tb/tb_ddr2_port_responder.sv
// tb/tb_ddr2_port_responder.sv - randomized self-checking bench for ddr2_port_responder
module tb_ddr2_port_responder;
  localparam int LAT   = 2;
  localparam int DEPTH = 640;

  logic        ctrl_clk = 1'b0;
  logic        reset_n;
  logic [31:0] write_addr, iData, read_addr;
  logic        write, read;
  logic        write_waitrequest, read_waitrequest;
  logic [31:0] oData, wr_count, rd_count;

  ddr2_port_responder #(.DEPTH(DEPTH), .ADDR_W(10), .LATENCY(LAT)) dut (
    .ctrl_clk(ctrl_clk), .reset_n(reset_n),
    .write_addr(write_addr), .iData(iData), .write(write),
    .write_waitrequest(write_waitrequest),
    .read_addr(read_addr), .read(read),
    .read_waitrequest(read_waitrequest), .oData(oData),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: word array, completion counts and who completed last.
  logic [31:0] ref_mem [DEPTH];
  int          ref_wr = 0;
  int          ref_rd = 0;
  bit          ref_last_rd = 1'b1;

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d);
    if (a < DEPTH * 4) ref_mem[a[11:2]] = d;
    ref_wr++;
    ref_last_rd = 1'b0;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    ref_rd++;
    ref_last_rd = 1'b1;
    return (a < DEPTH * 4) ? ref_mem[a[11:2]] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_cnt(input int c);
`ifdef DDR2_RESP_STATS_EN
    return 32'(c);
`else
    return 32'h0;
`endif
  endfunction

  // Issue one request from idle and wait (bounded) for its acknowledge.
  task automatic do_op(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                       output int lat, output bit other_ok, output logic [31:0] rdat);
    bit done;
    lat = 0; other_ok = 1'b1; rdat = 32'h0; done = 1'b0;
    @(negedge ctrl_clk);
    if (is_wr) begin write_addr = addr; iData = data; write = 1'b1; end
    else begin read_addr = addr; read = 1'b1; end
    for (int k = 1; k <= 20 && !done; k++) begin
      @(posedge ctrl_clk); #1;
      if (is_wr ? !read_waitrequest : !write_waitrequest) other_ok = 1'b0;
      if (is_wr ? !write_waitrequest : !read_waitrequest) begin
        lat = k; done = 1'b1; rdat = oData;
      end
    end
    write = 1'b0; read = 1'b0;
    @(posedge ctrl_clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; write = 1'b0; read = 1'b0;
    write_addr = '0; read_addr = '0; iData = '0;
    repeat (3) @(posedge ctrl_clk);
    #1;
    n_cmp++; if (write_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset_wwait: got %b expected 1", write_waitrequest); end
    n_cmp++; if (read_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset_rwait: got %b expected 1", read_waitrequest); end
    n_cmp++; if (oData !== 32'h0) begin n_err++; $display("FAIL reset_odata: got %h expected 0", oData); end
    n_cmp++; if (wr_count !== 32'h0) begin n_err++; $display("FAIL reset_wrcnt: got %h expected 0", wr_count); end
    n_cmp++; if (rd_count !== 32'h0) begin n_err++; $display("FAIL reset_rdcnt: got %h expected 0", rd_count); end
    @(negedge ctrl_clk);
    reset_n = 1'b1;
    @(posedge ctrl_clk); #1;
  endtask

  task automatic test_basic();
    int lat; bit ok; logic [31:0] r, e;
    do_op(1'b1, 32'd8, 32'hDEADBEEF, lat, ok, r);
    ref_write(32'd8, 32'hDEADBEEF);
    n_cmp++; if (lat !== LAT + 1) begin n_err++; $display("FAIL basic_wr_lat: got %0d expected %0d", lat, LAT + 1); end
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL basic_wr_rwait: got low expected high"); end
    do_op(1'b0, 32'd8, 32'h0, lat, ok, r);
    e = ref_read(32'd8);
    n_cmp++; if (lat !== LAT + 1) begin n_err++; $display("FAIL basic_rd_lat: got %0d expected %0d", lat, LAT + 1); end
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL basic_rd_wwait: got low expected high"); end
    n_cmp++; if (r !== e) begin n_err++; $display("FAIL basic_rd_data: got %h expected %h", r, e); end
    repeat (3) @(posedge ctrl_clk);
    #1;
    n_cmp++; if (oData !== e) begin n_err++; $display("FAIL basic_hold: got %h expected %h", oData, e); end
  endtask

  task automatic test_alternation();
    logic [31:0] wa, wd, e;
    int acks, cyc, prev, gap;
    bit both_low, got_wr, exp_wr;
    wa = 32'h40; wd = $urandom;
    acks = 0; cyc = 0; prev = 0; both_low = 1'b0;
    @(negedge ctrl_clk);
    write_addr = wa; iData = wd; write = 1'b1; read_addr = wa; read = 1'b1;
    while (acks < 4 && cyc < 60) begin
      @(posedge ctrl_clk); #1;
      cyc++;
      if (!write_waitrequest && !read_waitrequest) both_low = 1'b1;
      if (!write_waitrequest || !read_waitrequest) begin
        got_wr = !write_waitrequest;
        exp_wr = ref_last_rd;
        gap = (acks == 0) ? LAT + 1 : LAT + 2;
        n_cmp++; if (got_wr !== exp_wr) begin n_err++; $display("FAIL alt_order[%0d]: got wr=%b expected wr=%b", acks, got_wr, exp_wr); end
        n_cmp++; if (cyc - prev !== gap) begin n_err++; $display("FAIL alt_gap[%0d]: got %0d expected %0d", acks, cyc - prev, gap); end
        if (exp_wr) ref_write(wa, wd);
        else begin
          e = ref_read(wa);
          n_cmp++; if (oData !== e) begin n_err++; $display("FAIL alt_data[%0d]: got %h expected %h", acks, oData, e); end
        end
        prev = cyc; acks++;
        if (acks == 4) begin write = 1'b0; read = 1'b0; end
      end
    end
    write = 1'b0; read = 1'b0;
    n_cmp++; if (acks !== 4) begin n_err++; $display("FAIL alt_timeout: got %0d acks expected 4", acks); end
    n_cmp++; if (both_low !== 1'b0) begin n_err++; $display("FAIL alt_both_low: got 1 expected 0"); end
    @(posedge ctrl_clk); #1;
  endtask

  task automatic test_out_of_range();
    int lat; bit ok; logic [31:0] r, e, w0;
    w0 = $urandom;
    do_op(1'b1, 32'd0, w0, lat, ok, r); ref_write(32'd0, w0);
    do_op(1'b0, 32'd2560, 32'h0, lat, ok, r); e = ref_read(32'd2560);
    n_cmp++; if (lat !== LAT + 1) begin n_err++; $display("FAIL oor_rd_lat: got %0d expected %0d", lat, LAT + 1); end
    n_cmp++; if (r !== e) begin n_err++; $display("FAIL oor_rd_data: got %h expected %h", r, e); end
    do_op(1'b1, 32'd2560, ~w0, lat, ok, r); ref_write(32'd2560, ~w0);
    n_cmp++; if (lat !== LAT + 1) begin n_err++; $display("FAIL oor_wr_lat: got %0d expected %0d", lat, LAT + 1); end
    do_op(1'b1, 32'd4096, ~w0, lat, ok, r); ref_write(32'd4096, ~w0);
    do_op(1'b0, 32'd0, 32'h0, lat, ok, r); e = ref_read(32'd0);
    n_cmp++; if (r !== e) begin n_err++; $display("FAIL oor_word0: got %h expected %h", r, e); end
  endtask

  task automatic test_abort();
    int lat; bit ok, pulse; logic [31:0] r, e, od;
    od = oData; pulse = 1'b0;
    @(negedge ctrl_clk); read_addr = 32'd8; read = 1'b1;
    @(posedge ctrl_clk); #1; read = 1'b0;
    @(negedge ctrl_clk); write_addr = 32'd8; iData = ~ref_mem[2]; write = 1'b1;
    @(posedge ctrl_clk); #1; write = 1'b0;
    repeat (6) begin
      @(posedge ctrl_clk); #1;
      if (!write_waitrequest || !read_waitrequest) pulse = 1'b1;
    end
    n_cmp++; if (pulse !== 1'b0) begin n_err++; $display("FAIL abort_pulse: got 1 expected 0"); end
    n_cmp++; if (oData !== od) begin n_err++; $display("FAIL abort_odata: got %h expected %h", oData, od); end
    n_cmp++; if (rd_count !== exp_cnt(ref_rd)) begin n_err++; $display("FAIL abort_rdcnt: got %0d expected %0d", rd_count, exp_cnt(ref_rd)); end
    n_cmp++; if (wr_count !== exp_cnt(ref_wr)) begin n_err++; $display("FAIL abort_wrcnt: got %0d expected %0d", wr_count, exp_cnt(ref_wr)); end
    do_op(1'b0, 32'd8, 32'h0, lat, ok, r); e = ref_read(32'd8);
    n_cmp++; if (lat !== LAT + 1) begin n_err++; $display("FAIL abort_idle_lat: got %0d expected %0d", lat, LAT + 1); end
    n_cmp++; if (r !== e) begin n_err++; $display("FAIL abort_nowrite: got %h expected %h", r, e); end
  endtask

  task automatic test_sequential();
    int lat, bad_lat, bad_dat; bit ok; logic [31:0] r, e, d;
    bad_lat = 0; bad_dat = 0;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      do_op(1'b1, 32'(i * 4), d, lat, ok, r); ref_write(32'(i * 4), d);
      n_cmp++; if (lat !== LAT + 1 || !ok) begin n_err++; bad_lat++; if (bad_lat < 5) $display("FAIL seq_wr_lat[%0d]: got %0d expected %0d", i, lat, LAT + 1); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_op(1'b0, 32'(i * 4), 32'h0, lat, ok, r); e = ref_read(32'(i * 4));
      n_cmp++; if (r !== e || lat !== LAT + 1) begin n_err++; bad_dat++; if (bad_dat < 5) $display("FAIL seq_rd[%0d]: got %h lat %0d expected %h lat %0d", i, r, lat, e, LAT + 1); end
    end
    n_cmp++; if (wr_count !== exp_cnt(ref_wr)) begin n_err++; $display("FAIL seq_wrcnt: got %0d expected %0d", wr_count, exp_cnt(ref_wr)); end
    n_cmp++; if (rd_count !== exp_cnt(ref_rd)) begin n_err++; $display("FAIL seq_rdcnt: got %0d expected %0d", rd_count, exp_cnt(ref_rd)); end
  endtask

  task automatic test_random();
    int lat, bad; bit ok, is_wr; logic [31:0] r, e, a, d;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      is_wr = $urandom_range(0, 1);
      a = $urandom_range(0, 2800);
      d = $urandom;
      do_op(is_wr, a, d, lat, ok, r);
      if (is_wr) begin
        ref_write(a, d);
        n_cmp++; if (lat !== LAT + 1 || !ok) begin n_err++; bad++; if (bad < 5) $display("FAIL rnd_wr[%0d]: got lat %0d expected %0d", i, lat, LAT + 1); end
      end else begin
        e = ref_read(a);
        n_cmp++; if (r !== e || lat !== LAT + 1 || !ok) begin n_err++; bad++; if (bad < 5) $display("FAIL rnd_rd[%0d] addr %0d: got %h lat %0d expected %h lat %0d", i, a, r, lat, e, LAT + 1); end
      end
    end
    n_cmp++; if (wr_count !== exp_cnt(ref_wr)) begin n_err++; $display("FAIL rnd_wrcnt: got %0d expected %0d", wr_count, exp_cnt(ref_wr)); end
    n_cmp++; if (rd_count !== exp_cnt(ref_rd)) begin n_err++; $display("FAIL rnd_rdcnt: got %0d expected %0d", rd_count, exp_cnt(ref_rd)); end
  endtask

  task automatic test_reset_mid_op();
    int lat; bit ok; logic [31:0] r, e;
    @(negedge ctrl_clk); write_addr = 32'd0; iData = ~ref_mem[0]; write = 1'b1;
    @(posedge ctrl_clk); @(posedge ctrl_clk); #1;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (write_waitrequest !== 1'b1 || read_waitrequest !== 1'b1) begin n_err++; $display("FAIL midrst_wait: got %b%b expected 11", write_waitrequest, read_waitrequest); end
    n_cmp++; if (oData !== 32'h0 || wr_count !== 32'h0 || rd_count !== 32'h0) begin n_err++; $display("FAIL midrst_regs: got %h/%h/%h expected 0/0/0", oData, wr_count, rd_count); end
    write = 1'b0;
    ref_wr = 0; ref_rd = 0; ref_last_rd = 1'b1;
    @(negedge ctrl_clk); reset_n = 1'b1;
    do_op(1'b0, 32'd0, 32'h0, lat, ok, r); e = ref_read(32'd0);
    n_cmp++; if (r !== e) begin n_err++; $display("FAIL midrst_lost_write: got %h expected %h", r, e); end
    n_cmp++; if (rd_count !== exp_cnt(ref_rd)) begin n_err++; $display("FAIL midrst_rdcnt: got %0d expected %0d", rd_count, exp_cnt(ref_rd)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternation();
    test_out_of_range();
    test_abort();
    test_sequential();
    test_random();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
